// File: rtl/laplace_window_ctrl.sv
// laplace_window_ctrl
// Turns a raster pixel stream into the five-tap cross window (up, left,
// centre, right, down) used by a 3x3 laplace kernel. Two line buffers hold
// the previous two rows. Short shift registers supply the horizontal
// neighbours. Only interior centres produce a window. The window output
// is a ready/valid register that throttles the pixel input through pix_ready.
module laplace_window_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] win_b,
    output logic [7:0] win_d,
    output logic [7:0] win_e,
    output logic [7:0] win_f,
    output logic [7:0] win_h,
    output logic       win_valid,
    input  logic       win_ready,
    output logic       busy,
    output logic       done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  c;
    logic [RW-1:0]  r;

    // Line buffers: lb1[c] holds row r-1 and lb2[c] holds row r-2 at column c.
    logic [7:0]     lb1 [IMG_W];
    logic [7:0]     lb2 [IMG_W];

    // Horizontal history of the rows feeding the current window.
    logic [7:0]     up1_c1;   // row r-1, column c-1
    logic [7:0]     up1_c2;   // row r-1, column c-2
    logic [7:0]     up2_c1;   // row r-2, column c-1
    logic [7:0]     cur_c1;   // row r,   column c-1

    logic           accept;
    logic           last_col;
    logic           last_row;
    logic           has_win;
    logic [7:0]     lb1_rd;
    logic [7:0]     lb2_rd;

    assign pix_ready = (state == RUN) && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign busy      = (state != IDLE);

    assign last_col  = (c == CW'(IMG_W - 1));
    assign last_row  = (r == RW'(IMG_H - 1));
    assign has_win   = (r >= RW'(2)) && (c >= CW'(2));

    assign lb1_rd    = lb1[c];
    assign lb2_rd    = lb2[c];

    // Rotate the accepted pixel into the line buffers: this row's pixel goes
    // into lb1 and the older row it replaces moves down into lb2.
    // NOTE: the line buffers are deliberately not reset; a window is formed
    // only after rows 0 and 1 of the current frame have overwritten them, so
    // stale contents never reach the outputs and the arrays can map to RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[c] <= pix_in;
            lb2[c] <= lb1_rd;
        end
    end

    // Frame FSM, raster counters, tap shift registers and the output window register.
    // NOTE: every register here is assigned with <= so all right-hand sides
    // see pre-edge values; blocking assignments would make the shift chain
    // and the tap capture depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            up1_c1    <= '0;
            up1_c2    <= '0;
            up2_c1    <= '0;
            cur_c1    <= '0;
            win_b     <= '0;
            win_d     <= '0;
            win_e     <= '0;
            win_f     <= '0;
            win_h     <= '0;
            win_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        r     <= '0;
                        c     <= '0;
                    end
                end
                RUN: begin
                    if (accept && last_col && last_row) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!win_valid || win_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                if (last_col) begin
                    c <= '0;
                    r <= last_row ? '0 : r + RW'(1);
                end else begin
                    c <= c + CW'(1);
                end

                up1_c2 <= up1_c1;
                up1_c1 <= lb1_rd;
                up2_c1 <= lb2_rd;
                cur_c1 <= pix_in;

                // The window centred at (r-1, c-1) is complete once (r, c) arrives.
                win_valid <= has_win;
                if (has_win) begin
                    win_b <= up2_c1;
                    win_d <= up1_c2;
                    win_e <= up1_c1;
                    win_f <= lb1_rd;
                    win_h <= cur_c1;
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_laplace_window_ctrl.sv
// Testbench for laplace_window_ctrl. It drives a 4x4 instance and a 64x64
// instance from shared stimulus, with start steered by sel. Expected windows
// come from a bench-side model of the pixel pattern. They are queued when a
// pixel is accepted and compared when the window handshake fires.
module tb_laplace_window_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       win_ready;
    logic       sel;          // 0 -> 4x4 instance, 1 -> 64x64 instance
    int         frame_id;

    always #5 clk = ~clk;

    logic       s_ready, s_wvalid, s_busy, s_done;
    logic [7:0] s_b, s_d, s_e, s_f, s_h;
    logic       l_ready, l_wvalid, l_busy, l_done;
    logic [7:0] l_b, l_d, l_e, l_f, l_h;

    laplace_window_ctrl #(.IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start && !sel),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(s_ready),
        .win_b(s_b), .win_d(s_d), .win_e(s_e), .win_f(s_f), .win_h(s_h),
        .win_valid(s_wvalid), .win_ready(win_ready),
        .busy(s_busy), .done(s_done)
    );

    laplace_window_ctrl #(.IMG_W(64), .IMG_H(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start && sel),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(l_ready),
        .win_b(l_b), .win_d(l_d), .win_e(l_e), .win_f(l_f), .win_h(l_h),
        .win_valid(l_wvalid), .win_ready(win_ready),
        .busy(l_busy), .done(l_done)
    );

    logic        pix_ready, win_valid, busy, done;
    logic [39:0] taps;
    assign pix_ready = sel ? l_ready  : s_ready;
    assign win_valid = sel ? l_wvalid : s_wvalid;
    assign busy      = sel ? l_busy   : s_busy;
    assign done      = sel ? l_done   : s_done;
    assign taps      = sel ? {l_b, l_d, l_e, l_f, l_h} : {s_b, s_d, s_e, s_f, s_h};

    int checks = 0;
    int errors = 0;
    int win_cnt = 0;
    int done_cnt = 0;
    logic [39:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int img_w();
        return sel ? 64 : 4;
    endfunction

    function automatic int img_h();
        return sel ? 64 : 4;
    endfunction

    // Pixel pattern: 10r+c for the small frame, a frame-dependent mix for the large one.
    function automatic logic [7:0] pval(input int pr, input int pc);
        if (!sel) return 8'(10 * pr + pc);
        return 8'(pr * 3 + pc * 5 + frame_id * 101);
    endfunction

    // Scoreboard consumer: compare every handshaked window and count done pulses.
    always @(negedge clk) begin
        if (!rst && win_valid && win_ready) begin
            win_cnt++;
            if (exp_q.size() == 0) check("win_unexpected", 64'(exp_q.size()), 64'd1);
            else check("window", 64'(taps), 64'(exp_q.pop_front()));
        end
        if (!rst && done) done_cnt++;
    end

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic drive_pixels(input int n_pix, input bit gaps, input bit stall);
        int k = 0;
        int pr = 0;
        int pc = 0;
        int budget = 0;
        int stall_cnt = 0;
        bit stalled = 1'b0;
        while (k < n_pix && budget < 20000) begin
            pix_in    = pval(pr, pc);
            pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall && !stalled && win_valid) begin
                stalled   = 1'b1;
                stall_cnt = 5;
            end
            win_ready = (stall_cnt == 0);
            @(negedge clk);
            if (stall_cnt > 0) begin
                check("stall_taps", 64'(taps), 64'({8'd1, 8'd10, 8'd11, 8'd12, 8'd21}));
                check("stall_pix_ready", 64'(pix_ready), 64'd0);
                stall_cnt--;
            end
            if (pix_valid && pix_ready) begin
                if (pr >= 2 && pc >= 2)
                    exp_q.push_back({pval(pr-2, pc-1), pval(pr-1, pc-2), pval(pr-1, pc-1),
                                     pval(pr-1, pc), pval(pr, pc-1)});
                k++;
                pc++;
                if (pc == img_w()) begin
                    pc = 0;
                    pr++;
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        if (budget >= 20000) check("drive_timeout", 64'(k), 64'(n_pix));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic run_frame(input bit gaps, input bit stall);
        int d0;
        d0 = done_cnt;
        win_cnt = 0;
        start_frame();
        drive_pixels(img_w() * img_h(), gaps, stall);
        wait_done();
        repeat (3) begin @(posedge clk); #1; end
        check("win_count", 64'(win_cnt), 64'((img_w() - 2) * (img_h() - 2)));
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; pix_in = '0; pix_valid = 1'b0;
        win_ready = 1'b1; sel = 1'b0; frame_id = 0;
        repeat (2) @(posedge clk);
        // Start is held high during reset to confirm reset overrides it.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b0;
        check("rst_win_valid", 64'(win_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pix_ready", 64'(pix_ready), 64'd0);
        check("rst_taps", 64'(taps), 64'd0);

        // Basic 4x4 frame, consumer always ready.
        run_frame(1'b0, 1'b0);
        // Consumer stalls for five cycles on the first window.
        run_frame(1'b0, 1'b1);
        // Random input gaps.
        run_frame(1'b1, 1'b0);

        // Reset mid-frame, then a clean restart.
        d0 = done_cnt;
        start_frame();
        drive_pixels(7, 1'b0, 1'b0);
        check("no_done_before_rst", 64'(done_cnt - d0), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_win_valid", 64'(win_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_pix_ready", 64'(pix_ready), 64'd0);
        check("midrst_taps", 64'(taps), 64'd0);
        exp_q.delete();
        run_frame(1'b0, 1'b0);

        // 64x64 back-to-back frames, second start issued on the done cycle.
        sel = 1'b1;
        frame_id = 0;
        win_cnt = 0;
        d0 = done_cnt;
        start_frame();
        drive_pixels(64 * 64, 1'b0, 1'b0);
        wait_done();
        check("big_f0_windows", 64'(win_cnt), 64'd3844);
        frame_id = 1;
        win_cnt = 0;
        start_frame();
        drive_pixels(64 * 64, 1'b0, 1'b0);
        wait_done();
        repeat (3) begin @(posedge clk); #1; end
        check("big_f1_windows", 64'(win_cnt), 64'd3844);
        check("big_done_pulses", 64'(done_cnt - d0), 64'd2);
        check("big_queue_empty", 64'(exp_q.size()), 64'd0);
        check("big_idle_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
